pong_serve_gen: RTL and testbench
=================================

Name: pong_serve_gen

Overview:
- Consumes the free-running 32-bit pseudo-random word from the Pong random number generator.
- On a serve request, waits a fixed serve delay. It then draws a random ball start row and a random velocity using rejection sampling on the row.
- Presents the result to the ball-motion logic through a valid/ack handshake.
- Sits between the game-control FSM (which requests serves) and the ball position/velocity registers (which consume the result).

Parameters:
- Y_W, 10: width of ball_y and of the row candidate taken from rnd_num[Y_W-1:0].
- Y_MIN, 16: lowest legal start row, inclusive.
- Y_MAX, 463: highest legal start row, inclusive.
- SPEED_MIN, 1: minimum horizontal speed magnitude.
- SPEED_MAX, 4: saturation limit for both speed magnitudes (must be ≤ 7).
- DELAY_CYC, 1000: number of cycles spent in DELAY (≥ 1).
- MAX_TRIES, 8: number of draws before fallback (≥ 1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rnd_num  in  32  random word; a new value is assumed each cycle
- serve_req  in  1  single-cycle serve request; sampled only in IDLE
- serve_side  in  1  sampled with serve_req; 0 = left serves (ball moves right), 1 = right serves
- serve_ack  in  1  consumer accepts the serve
- busy  out  1  high in any state other than IDLE
- serve_valid  out  1  high in HOLD
- ball_y  out  Y_W  start row
- ball_dx  out  4  signed two's-complement horizontal velocity
- ball_dy  out  4  signed two's-complement vertical velocity

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high (rst).
- Reset state: FSM in IDLE; busy, serve_valid, ball_y, ball_dx, ball_dy all 0; counters cleared.
- rst asserted in any state aborts the operation and returns the block to IDLE on the next edge. No serve_valid pulse is produced.
- States: IDLE, DELAY, DRAW, HOLD.
- IDLE:
  - When serve_req=1: latch serve_side, load delay counter with DELAY_CYC-1, go to DELAY.
  - When serve_req=0: stay in IDLE.
- DELAY:
  - Decrement the delay counter each cycle.
  - The state lasts exactly DELAY_CYC cycles.
  - When the count reaches 0: clear the try counter, go to DRAW.
- DRAW: one draw per cycle from the current rnd_num.
  - Row candidate: c = rnd_num[Y_W-1:0], unsigned. Accept if Y_MIN ≤ c ≤ Y_MAX.
  - On accept: ball_y = c.
  - On reject with try counter < MAX_TRIES-1: increment the try counter and stay in DRAW.
  - On reject with try counter = MAX_TRIES-1: ball_y = (Y_MIN+Y_MAX)/2, using truncating integer division.
  - Horizontal magnitude: dx_mag = min(SPEED_MIN + rnd_num[17:16], SPEED_MAX).
  - Vertical magnitude: dy_mag = min(rnd_num[20:18], SPEED_MAX).
  - ball_dx = +dx_mag when the latched side is 0, otherwise -dx_mag.
  - ball_dy = -dy_mag when rnd_num[21]=1, otherwise +dy_mag. dy_mag = 0 gives ball_dy = 0 regardless of sign.
  - Velocities come from the same rnd_num sample as the accepted (or final fallback) row.
  - The accepted or fallback result is registered and the FSM goes to HOLD.
- HOLD:
  - serve_valid=1; ball_y, ball_dx and ball_dy are held stable.
  - When serve_ack=1: go to IDLE; serve_valid drops on the next cycle.
  - serve_ack in any other state is ignored.
- serve_req while busy=1 is ignored, including in the same cycle as serve_ack. The requester must re-pulse serve_req.
- Outputs retain their last value in IDLE after a serve. Only rst clears them.
- Latency with serve_req at cycle 0:
  - DELAY occupies cycles 1..DELAY_CYC.
  - The first draw is at cycle DELAY_CYC+1.
  - serve_valid=1 at cycle DELAY_CYC+1+k, where k is the accepted try index (1 ≤ k ≤ MAX_TRIES).

Decomposition:
- Shared package pong_pkg holds:
  - FSM state encoding (2-bit).
  - Velocity width constant VEL_W=4.
  - rnd_num bit-field positions: DX_LSB=16, DY_LSB=18, DY_SIGN=21.
  - Default playfield bounds Y_MIN and Y_MAX.
- One natural sub-module: pong_vel_map. It is purely combinational: rnd_num bits plus side in, saturated signed ball_dx and ball_dy out. It is reused by the paddle-hit re-angle logic.

Test Plan:
- Basic serve: DELAY_CYC=4, rnd_num held at 32'h0000_0064, pulse serve_req with side=0 at cycle 0 -> serve_valid=1 at cycle 6 with ball_y=100, ball_dx=+1 (4'h1), ball_dy=0.
- Saturated velocity: rnd_num=32'h0033_0064, side=1 -> ball_y=100, ball_dx=-4 (4'hC), ball_dy=-4 (4'hC).
- Rejection then accept: rnd_num=32'h0000_01F4 (row 500) on the first two draws, then 32'h0000_0010 -> accepted on the third draw, ball_y=16, serve_valid 2 cycles later than the basic case.
- Fallback: rnd_num held at 32'h0000_03FF, MAX_TRIES=8 -> after 8 draws ball_y=239, ball_dx=+1, ball_dy=0; serve_valid at cycle DELAY_CYC+9.
- Handshake: hold serve_ack=0 for 10 cycles in HOLD -> outputs stable and serve_valid=1 throughout. Then assert serve_ack together with serve_req -> return to IDLE, busy=0 next cycle, and the request is not started.
- Reset mid-operation: assert rst for 1 cycle during DELAY, and separately during HOLD -> next cycle in IDLE with all outputs 0. No serve_valid appears afterwards without a new serve_req.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong definitions: serve FSM encoding, velocity width, rnd_num field
// positions, default playfield bounds and a saturation helper.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_DRAW  = 2'd2,
        ST_HOLD  = 2'd3
    } serve_state_t;

    localparam int VEL_W   = 4;
    localparam int DX_LSB  = 16;
    localparam int DY_LSB  = 18;
    localparam int DY_SIGN = 21;

    localparam int Y_MIN_DEF = 16;
    localparam int Y_MAX_DEF = 463;

    // Clamp an unsigned magnitude to an upper limit.
    function automatic logic [VEL_W-1:0] sat_mag(input logic [VEL_W-1:0] val,
                                                 input logic [VEL_W-1:0] lim);
        if (val > lim) begin
            return lim;
        end else begin
            return val;
        end
    endfunction

endpackage

// File: rtl/pong_vel_map.sv
// Maps random bits plus serving side to saturated signed ball velocities.
// Purely combinational; also used by the paddle-hit re-angle logic.
module pong_vel_map
    import pong_pkg::*;
#(
    parameter int SPEED_MIN = 1,
    parameter int SPEED_MAX = 4
) (
    input  logic [31:0]             rnd_num,
    input  logic                    side,
    output logic signed [VEL_W-1:0] ball_dx,
    output logic signed [VEL_W-1:0] ball_dy
);

    logic [VEL_W-1:0] dx_sum_s;
    logic [VEL_W-1:0] dx_mag_s;
    logic [VEL_W-1:0] dy_mag_s;
    logic             unused_rnd_s;

    // Only a few bits of the word matter here; fold the rest away.
    assign unused_rnd_s = ^rnd_num;

    // Magnitudes, saturation and sign selection.
    always_comb begin
        dx_sum_s = VEL_W'(SPEED_MIN) + {2'b00, rnd_num[DX_LSB +: 2]};
        dx_mag_s = sat_mag(dx_sum_s, VEL_W'(SPEED_MAX));
        dy_mag_s = sat_mag({1'b0, rnd_num[DY_LSB +: 3]}, VEL_W'(SPEED_MAX));
        if (side) begin
            ball_dx = -dx_mag_s;
        end else begin
            ball_dx = dx_mag_s;
        end
        if (rnd_num[DY_SIGN]) begin
            ball_dy = -dy_mag_s;
        end else begin
            ball_dy = dy_mag_s;
        end
    end

endmodule

// File: rtl/pong_serve_gen.sv
// Serve generator: after a serve request, waits a fixed delay, draws a random
// start row by rejection sampling plus random velocities, and holds them until acked.
module pong_serve_gen
    import pong_pkg::*;
#(
    parameter int Y_W       = 10,
    parameter int Y_MIN     = Y_MIN_DEF,
    parameter int Y_MAX     = Y_MAX_DEF,
    parameter int SPEED_MIN = 1,
    parameter int SPEED_MAX = 4,
    parameter int DELAY_CYC = 1000,
    parameter int MAX_TRIES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             rnd_num,
    input  logic                    serve_req,
    input  logic                    serve_side,
    input  logic                    serve_ack,
    output logic                    busy,
    output logic                    serve_valid,
    output logic [Y_W-1:0]          ball_y,
    output logic signed [VEL_W-1:0] ball_dx,
    output logic signed [VEL_W-1:0] ball_dy
);

    localparam int DCNT_W = $clog2(DELAY_CYC + 1);
    localparam int TCNT_W = $clog2(MAX_TRIES + 1);

    localparam logic [DCNT_W-1:0] DELAY_LOAD = DCNT_W'(DELAY_CYC - 1);
    localparam logic [TCNT_W-1:0] LAST_TRY   = TCNT_W'(MAX_TRIES - 1);
    localparam logic [Y_W-1:0]    Y_LO       = Y_W'(Y_MIN);
    localparam logic [Y_W-1:0]    Y_HI       = Y_W'(Y_MAX);
    localparam logic [Y_W-1:0]    Y_MID      = Y_W'((Y_MIN + Y_MAX) / 2);

    serve_state_t             state_r;
    logic                     side_r;
    logic [DCNT_W-1:0]        delay_cnt_r;
    logic [TCNT_W-1:0]        try_cnt_r;

    logic [Y_W-1:0]           cand_s;
    logic                     accept_s;
    logic                     last_try_s;
    logic signed [VEL_W-1:0]  dx_s;
    logic signed [VEL_W-1:0]  dy_s;

    assign cand_s     = rnd_num[Y_W-1:0];
    assign accept_s   = (cand_s >= Y_LO) && (cand_s <= Y_HI);
    assign last_try_s = (try_cnt_r == LAST_TRY);

    pong_vel_map #(
        .SPEED_MIN (SPEED_MIN),
        .SPEED_MAX (SPEED_MAX)
    ) u_vel_map (
        .rnd_num (rnd_num),
        .side    (side_r),
        .ball_dx (dx_s),
        .ball_dy (dy_s)
    );

    // Serve FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            side_r      <= 1'b0;
            delay_cnt_r <= '0;
            try_cnt_r   <= '0;
            busy        <= 1'b0;
            serve_valid <= 1'b0;
            ball_y      <= '0;
            ball_dx     <= '0;
            ball_dy     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (serve_req) begin
                        side_r      <= serve_side;
                        delay_cnt_r <= DELAY_LOAD;
                        busy        <= 1'b1;
                        state_r     <= ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (delay_cnt_r == '0) begin
                        try_cnt_r <= '0;
                        state_r   <= ST_DRAW;
                    end else begin
                        delay_cnt_r <= delay_cnt_r - 1'b1;
                    end
                end
                ST_DRAW: begin
                    // Velocities always come from the same sample as the row.
                    if (accept_s || last_try_s) begin
                        ball_y      <= accept_s ? cand_s : Y_MID;
                        ball_dx     <= dx_s;
                        ball_dy     <= dy_s;
                        serve_valid <= 1'b1;
                        state_r     <= ST_HOLD;
                    end else begin
                        try_cnt_r <= try_cnt_r + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (serve_ack) begin
                        serve_valid <= 1'b0;
                        busy        <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    serve_valid <= 1'b0;
                    busy        <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_serve_gen.sv
// Self-checking bench for pong_serve_gen: table-driven serves with a scoreboard,
// plus handshake and mid-operation reset sequences.
module tb_pong_serve_gen;

    localparam int D  = 4;
    localparam int MT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       rnd_num;
    logic              serve_req;
    logic              serve_side;
    logic              serve_ack;
    logic              busy;
    logic              serve_valid;
    logic [9:0]        ball_y;
    logic signed [3:0] ball_dx;
    logic signed [3:0] ball_dy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] w_rej;
        int          nrej;
        logic [31:0] w_acc;
        logic        side;
        logic [9:0]  y;
        logic [3:0]  dx;
        logic [3:0]  dy;
        int          lat;
    } vec_t;

    typedef struct {
        logic [9:0] y;
        logic [3:0] dx;
        logic [3:0] dy;
        int         lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[12];

    pong_serve_gen #(.DELAY_CYC(D), .MAX_TRIES(MT)) dut (
        .clk         (clk),
        .rst         (rst),
        .rnd_num     (rnd_num),
        .serve_req   (serve_req),
        .serve_side  (serve_side),
        .serve_ack   (serve_ack),
        .busy        (busy),
        .serve_valid (serve_valid),
        .ball_y      (ball_y),
        .ball_dx     (ball_dx),
        .ball_dy     (ball_dy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issue one serve and compare the first serve_valid cycle against the scoreboard.
    task automatic run_serve(input vec_t v);
        exp_t e;
        int   n;
        int   idx;
        bit   got;
        @(negedge clk);
        rnd_num    = (v.nrej > 0) ? v.w_rej : v.w_acc;
        serve_side = v.side;
        serve_req  = 1'b1;
        e.y = v.y; e.dx = v.dx; e.dy = v.dy; e.lat = v.lat;
        sb_q.push_back(e);
        @(posedge clk);
        #1 serve_req = 1'b0;
        serve_side = ~v.side;
        n   = 1;
        got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            if (serve_valid) begin
                got = 1'b1;
            end else begin
                idx = n - (D + 1);
                rnd_num = (idx < v.nrej) ? v.w_rej : v.w_acc;
                @(posedge clk);
                n++;
            end
        end
        e = sb_q.pop_front();
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL serve_timeout actual=none expected=valid_at_%0d", e.lat);
        end else begin
            chk("latency", 32'(n), 32'(e.lat));
            chk("ball_y", {22'd0, ball_y}, {22'd0, e.y});
            chk("ball_dx", {28'd0, ball_dx}, {28'd0, e.dx});
            chk("ball_dy", {28'd0, ball_dy}, {28'd0, e.dy});
            chk("busy_hold", {31'd0, busy}, 32'd1);
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        serve_ack = 1'b1;
        @(posedge clk);
        #1 serve_ack = 1'b0;
        @(negedge clk);
        chk("valid_after_ack", {31'd0, serve_valid}, 32'd0);
        chk("busy_after_ack", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_valid"}, {31'd0, serve_valid}, 32'd0);
        chk({tag, "_y"}, {22'd0, ball_y}, 32'd0);
        chk({tag, "_dx"}, {28'd0, ball_dx}, 32'd0);
        chk({tag, "_dy"}, {28'd0, ball_dy}, 32'd0);
    endtask

    task automatic watch_no_valid(input string tag);
        int seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (serve_valid || busy) seen++;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int hold_bad;
        //           w_rej         nrej w_acc         side y     dx    dy    lat
        vecs[0]  = '{32'h0,        0, 32'h0000_0064, 1'b0, 10'd100, 4'h1, 4'h0, 6};
        vecs[1]  = '{32'h0,        0, 32'h0033_0064, 1'b1, 10'd100, 4'hC, 4'hC, 6};
        vecs[2]  = '{32'h0000_01F4, 2, 32'h0000_0010, 1'b0, 10'd16,  4'h1, 4'h0, 8};
        vecs[3]  = '{32'h0,        0, 32'h0000_03FF, 1'b0, 10'd239, 4'h1, 4'h0, 13};
        vecs[4]  = '{32'h0,        0, 32'h0000_01CF, 1'b0, 10'd463, 4'h1, 4'h0, 6};
        vecs[5]  = '{32'h0,        0, 32'h0000_01D0, 1'b1, 10'd239, 4'hF, 4'h0, 13};
        vecs[6]  = '{32'h0,        0, 32'h0000_000F, 1'b0, 10'd239, 4'h1, 4'h0, 13};
        vecs[7]  = '{32'h0,        0, 32'h0009_0064, 1'b0, 10'd100, 4'h2, 4'h2, 6};
        vecs[8]  = '{32'h0,        0, 32'h0009_0064, 1'b1, 10'd100, 4'hE, 4'h2, 6};
        vecs[9]  = '{32'h0,        0, 32'h0024_0064, 1'b0, 10'd100, 4'h1, 4'hF, 6};
        vecs[10] = '{32'h0,        0, 32'h0020_0064, 1'b0, 10'd100, 4'h1, 4'h0, 6};
        vecs[11] = '{32'h0000_03FF, 7, 32'h0000_01CF, 1'b0, 10'd463, 4'h1, 4'h0, 13};

        rst = 1'b1; rnd_num = 32'h0; serve_req = 1'b0; serve_side = 1'b0; serve_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_cleared("reset");

        for (int i = 0; i < 12; i++) begin
            run_serve(vecs[i]);
            do_ack();
            chk("retain_y", {22'd0, ball_y}, {22'd0, vecs[i].y});
        end

        // Held serve: outputs must stay put until acked; ack+req together does not restart.
        run_serve(vecs[1]);
        hold_bad = 0;
        repeat (10) begin
            @(negedge clk);
            rnd_num = $urandom;
            if (!serve_valid || ball_y != 10'd100 || ball_dx != 4'hC || ball_dy != 4'hC)
                hold_bad++;
        end
        chk("hold_stable", 32'(hold_bad), 32'd0);
        @(negedge clk);
        serve_ack = 1'b1; serve_req = 1'b1; serve_side = 1'b0;
        @(posedge clk);
        #1 serve_ack = 1'b0; serve_req = 1'b0;
        @(negedge clk);
        chk("ackreq_busy", {31'd0, busy}, 32'd0);
        chk("ackreq_valid", {31'd0, serve_valid}, 32'd0);
        watch_no_valid("ackreq_no_restart");

        // Reset during DELAY.
        @(negedge clk);
        rnd_num = 32'h0033_0064; serve_side = 1'b1; serve_req = 1'b1;
        @(posedge clk);
        #1 serve_req = 1'b0;
        @(negedge clk);
        chk("delay_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_cleared("rst_delay");
        watch_no_valid("rst_delay_quiet");

        // Reset during HOLD.
        run_serve(vecs[1]);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_cleared("rst_hold");
        watch_no_valid("rst_hold_quiet");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
